guess_round_ctrl: RTL and testbench

- Game sequencer for the binary-guess game.
- Requests a fresh 8-bit target from the free-running random number generator by pulsing that generator's capture input.
- Runs a timed round per target, compares the player's switch guess on each submit, and tracks score and round count up to game over.
- Sits between the debounced button/switch inputs, the random generator, and the display/scoreboard logic.

---
 rtl/guess_pkg.sv | 15 +
 rtl/guess_round_ctrl_if.sv | 20 ++
 rtl/guess_round_ctrl_round_timer.sv | 19 +
 rtl/guess_round_ctrl.sv | 75 +++++++
 tb/tb_guess_round_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/guess_pkg.sv
// guess_pkg: shared state encoding and default sizes for the guess game (state_t IDLE..DONE, WIDTH/ROUND_TIME/NUM_ROUNDS defaults)
package guess_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int ROUND_TIME_DEF = 30;
  localparam int NUM_ROUNDS_DEF = 10;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    SEED = 3'd2,
    PLAY = 3'd3,
    HIT  = 3'd4,
    MISS = 3'd5,
    DONE = 3'd6
  } state_t;
endpackage

// File: rtl/guess_round_ctrl_if.sv
// guess_round_ctrl_if: game bus; master drives start/submit/guess/target/tick, slave returns new_target/state_o/score/round/time_left/hit/wrong/game_over
interface guess_round_ctrl_if import guess_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TW = $clog2(ROUND_TIME_DEF + 1)
) ();
  logic start, submit, tick;
  logic [WIDTH-1:0] guess, target;
  logic new_target, hit, wrong, game_over;
  logic [2:0] state_o;
  logic [3:0] score, round;
  logic [TW-1:0] time_left;
  modport master (
    output start, submit, guess, target, tick,
    input new_target, state_o, score, round, time_left, hit, wrong, game_over
  );
  modport slave (
    input start, submit, guess, target, tick,
    output new_target, state_o, score, round, time_left, hit, wrong, game_over
  );
endinterface

// File: rtl/guess_round_ctrl_round_timer.sv
// round_timer: loadable seconds down-counter; in clk/rst/load/en/tick, out time_left (resets to ROUND_TIME) and expire (tick taking it from 1 to 0)
module round_timer #(
  parameter int ROUND_TIME = 30,
  parameter int TW = $clog2(ROUND_TIME + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic          tick,
  output logic [TW-1:0] time_left,
  output logic          expire
);
  logic [TW-1:0] time_q, time_d;
  always_comb time_d = load ? TW'(ROUND_TIME) : (en && tick && time_q != '0) ? time_q - 1'b1 : time_q;
  always_ff @(posedge clk) time_q <= rst ? TW'(ROUND_TIME) : time_d;
  assign expire = en && tick && time_q == TW'(1);
  assign time_left = time_q;
endmodule

// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: round sequencer (clk, rst, slave bus: start/submit/guess/target/tick in; new_target/state_o/score/round/time_left/hit/wrong/game_over out); GUESS_NONZERO_TARGET_EN re-requests zero targets
module guess_round_ctrl import guess_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ROUND_TIME = ROUND_TIME_DEF,
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input logic clk,
  input logic rst,
  guess_round_ctrl_if.slave bus
);
  localparam int TW = $clog2(ROUND_TIME + 1);
  state_t state_q, state_d;
  logic [3:0] score_q, score_d, round_q, round_d;
  logic [WIDTH-1:0] g, t;
  logic correct, load, en, expire, last;
  assign g = bus.guess;
  assign t = bus.target;
  assign correct = bus.submit && g == t;
  assign en = state_q == PLAY && !correct;
  assign last = round_q + 4'd1 == 4'(NUM_ROUNDS);
  round_timer #(.ROUND_TIME(ROUND_TIME), .TW(TW)) u_timer (
    .clk(clk), .rst(rst), .load(load), .en(en), .tick(bus.tick),
    .time_left(bus.time_left), .expire(expire)
  );
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    round_d = round_q;
    load = 1'b0;
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        state_d = REQ;
        score_d = '0;
        round_d = '0;
      end
      REQ: state_d = SEED;
`ifdef GUESS_NONZERO_TARGET_EN
      SEED: begin
        state_d = t == '0 ? REQ : PLAY;
        load = t != '0;
      end
`else
      SEED: begin
        state_d = PLAY;
        load = 1'b1;
      end
`endif
      PLAY: state_d = correct ? HIT : expire ? MISS : PLAY;
      HIT, MISS: begin
        score_d = (state_q == HIT && score_q != 4'hf) ? score_q + 4'd1 : score_q;
        round_d = round_q + 4'd1;
        state_d = last ? DONE : REQ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      score_q <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      round_q <= round_d;
    end
  end
  assign bus.new_target = state_q == REQ;
  assign bus.hit = state_q == PLAY && correct;
  assign bus.wrong = state_q == PLAY && bus.submit && !correct;
  assign bus.game_over = state_q == DONE;
  assign bus.state_o = state_q;
  assign bus.score = score_q;
  assign bus.round = round_q;
endmodule

// File: tb/tb_guess_round_ctrl.sv
// tb_guess_round_ctrl: directed plus random game play against a round-level model, checked through an expectation queue
module tb_guess_round_ctrl;
  import guess_pkg::*;
  localparam int RT = 6;
  localparam int NR = 3;
  localparam int W = 8;
  localparam int TW = $clog2(RT + 1);
  typedef struct packed {
    logic [2:0] st;
    logic nt, hi, wr, go;
    logic [3:0] sc, rd;
    logic [TW-1:0] tl;
  } rec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] gen_val;
  always #5 clk = ~clk;
  guess_round_ctrl_if #(.WIDTH(W), .TW(TW)) bus ();
  guess_round_ctrl #(.WIDTH(W), .ROUND_TIME(RT), .NUM_ROUNDS(NR)) dut (.clk(clk), .rst(rst), .bus(bus));
  always @(posedge clk) if (rst) bus.target <= '0; else if (bus.new_target) bus.target <= gen_val;
  rec_t q[$];
  int vectors = 0;
  int miscompares = 0;
  bit chk = 1'b0;
  bit m_on, m_over, m_post, m_phit;
  int m_pre, m_t, m_sc, m_rd;
  logic [W-1:0] m_tgt;
  function automatic rec_t m_out();
    rec_t r;
    bit play;
    play = m_on && m_pre == 0 && !m_post;
    r.st = m_over ? 3'd6 : !m_on ? 3'd0 : m_pre == 2 ? 3'd1 : m_pre == 1 ? 3'd2 : m_post ? (m_phit ? 3'd4 : 3'd5) : 3'd3;
    r.nt = m_on && m_pre == 2;
    r.hi = play && bus.submit && bus.guess == m_tgt;
    r.wr = play && bus.submit && bus.guess != m_tgt;
    r.go = m_over;
    r.sc = 4'(m_sc);
    r.rd = 4'(m_rd);
    r.tl = TW'(m_t);
    return r;
  endfunction
  task automatic check(input bit ok, input string msg);
    if (!ok) begin
      miscompares++;
      $display("FAIL %s @%0t: st=%0d nt=%0b hit=%0b wrong=%0b go=%0b score=%0d round=%0d tl=%0d",
        msg, $time, bus.state_o, bus.new_target, bus.hit, bus.wrong, bus.game_over, bus.score, bus.round, bus.time_left);
    end
  endtask
  task automatic m_update();
    bit zero_retry;
`ifdef GUESS_NONZERO_TARGET_EN
    zero_retry = m_tgt == '0;
`else
    zero_retry = 1'b0;
`endif
    if (rst) begin
      m_on = 0; m_over = 0; m_post = 0; m_phit = 0;
      m_pre = 0; m_t = RT; m_sc = 0; m_rd = 0; m_tgt = '0;
    end else if (!m_on) begin
      if (bus.start) begin
        m_on = 1; m_over = 0; m_sc = 0; m_rd = 0; m_pre = 2;
      end
    end else if (m_pre == 2) begin
      m_pre = 1;
      m_tgt = gen_val;
    end else if (m_pre == 1) begin
      if (zero_retry) m_pre = 2;
      else begin
        m_pre = 0;
        m_t = RT;
      end
    end else if (m_post) begin
      if (m_phit && m_sc < 15) m_sc++;
      m_rd++;
      m_post = 0;
      if (m_rd == NR) begin
        m_on = 0;
        m_over = 1;
      end else m_pre = 2;
    end else if (bus.submit && bus.guess == m_tgt) begin
      m_post = 1;
      m_phit = 1;
    end else if (bus.tick) begin
      m_t--;
      if (m_t == 0) begin
        m_post = 1;
        m_phit = 0;
      end
    end
  endtask
  task automatic cyc(input bit r, s, sb, tk, input logic [W-1:0] g, gv);
    @(negedge clk);
    rst = r;
    bus.start = s;
    bus.submit = sb;
    bus.tick = tk;
    bus.guess = g;
    gen_val = gv;
    #1;
    if (chk) q.push_back(m_out());
    m_update();
    if (r) chk = 1'b1;
  endtask
  always @(negedge clk) begin : monitor
    rec_t e, a;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {bus.state_o, bus.new_target, bus.hit, bus.wrong, bus.game_over, bus.score, bus.round, bus.time_left};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec%0d @%0t: got st=%0d nt=%0b hit=%0b wrong=%0b go=%0b score=%0d round=%0d tl=%0d, want st=%0d nt=%0b hit=%0b wrong=%0b go=%0b score=%0d round=%0d tl=%0d",
          vectors, $time, a.st, a.nt, a.hi, a.wr, a.go, a.sc, a.rd, a.tl, e.st, e.nt, e.hi, e.wr, e.go, e.sc, e.rd, e.tl);
      end
    end
  end
  initial begin
    bus.start = 0; bus.submit = 0; bus.tick = 0; bus.guess = '0; gen_val = '0;
    m_on = 0; m_over = 0; m_post = 0; m_phit = 0; m_pre = 0; m_t = RT; m_sc = 0; m_rd = 0; m_tgt = '0;
    repeat (2) cyc(1, 0, 0, 0, 8'h00, 8'h00);
    check(bus.state_o == 3'd0 && !bus.new_target && !bus.hit && !bus.wrong && !bus.game_over &&
          bus.score == 4'd0 && bus.round == 4'd0 && bus.time_left == TW'(RT), "reset state");
    cyc(0, 0, 1, 1, 8'h00, 8'h00);
    cyc(0, 1, 0, 0, 8'h00, 8'h5A);
    repeat (2) cyc(0, 0, 0, 0, 8'h00, 8'h5A);
    cyc(0, 0, 1, 0, 8'h3C, 8'h5A);
    cyc(0, 0, 1, 0, 8'h5A, 8'h5A);
    repeat (3) cyc(0, 0, 0, 0, 8'h00, 8'h5A);
    repeat (RT - 1) cyc(0, 0, 0, 1, 8'h00, 8'h5A);
    cyc(0, 0, 1, 1, 8'h5A, 8'h5A);
    repeat (3) cyc(0, 0, 0, 0, 8'h00, 8'h5A);
    cyc(0, 0, 1, 1, 8'h3C, 8'h5A);
    repeat (RT - 1) cyc(0, 0, 0, 1, 8'h00, 8'h5A);
    cyc(0, 0, 1, 1, 8'h00, 8'h5A);
    check(bus.state_o == 3'd5 && bus.time_left == '0, "expired wait");
    repeat (2) cyc(0, 0, 1, 1, 8'h00, 8'h5A);
    cyc(0, 1, 0, 0, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 8'h00, 8'h00);
    repeat (3) cyc(0, 0, 0, 0, 8'h00, 8'h11);
    cyc(0, 0, 1, 0, 8'h11, 8'h11);
    repeat (3) cyc(0, 0, 0, 0, 8'h00, 8'h22);
    cyc(0, 0, 0, 1, 8'h00, 8'h22);
    cyc(1, 0, 0, 0, 8'h00, 8'h22);
    repeat (2) cyc(0, 0, 0, 0, 8'h00, 8'h22);
    for (int i = 0; i < 4000; i++) begin
      logic [W-1:0] g, gv;
      g = ($urandom_range(0, 2) == 0) ? m_tgt : W'($urandom);
      gv = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      cyc($urandom_range(0, 599) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 2) == 0, g, gv);
    end
    repeat (3) cyc(0, 0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
